// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_pkg
// Purpose  : Shared types and constants for the data-memory responder.
// Revision : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

   // Must track the core's data/address width.
   localparam int unsigned CORE_DATA_WIDTH = 32;
   localparam int unsigned DATA_BE_WIDTH   = 4;

   typedef struct packed {
      logic                       valid;
      logic [CORE_DATA_WIDTH-1:0] rdata;
   } data_resp_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_resp_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_resp_delay_line
// Purpose  : Fixed-depth shift register of responses with synchronous clear.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_responder_resp_delay_line
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  data_resp_t i_resp,
   output data_resp_t o_resp,
   output logic       o_last_load
);

   data_resp_t r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_resp;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   // Valid bit about to enter the output stage on the next edge.
   generate
      if (DEPTH == 1) begin : g_single
         assign o_last_load = i_resp.valid;
      end else begin : g_multi
         assign o_last_load = r_stage[DEPTH-2].valid;
      end
   endgenerate

   assign o_resp = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory responder: req/gnt/rvalid slave with word RAM.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = CORE_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH      = 10,
   parameter int unsigned READ_LATENCY    = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     data_req_i,
   output logic                     data_gnt_o,
   input  logic [DATA_WIDTH-1:0]    data_addr_i,
   input  logic                     data_we_i,
   input  logic [DATA_BE_WIDTH-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]    data_wdata_i,
   output logic                     data_rvalid_o,
   output logic [DATA_WIDTH-1:0]    data_rdata_o
);

   localparam int unsigned        c_cnt_w   = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned        c_depth   = 2**ADDR_WIDTH;
   localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUTSTANDING);
   localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

   logic [DATA_WIDTH-1:0] r_mem [c_depth];
   logic [c_cnt_w-1:0]    r_count;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_gnt;
   logic                  w_retire;
   logic                  w_unused_addr;
   data_resp_t            w_resp_in;
   data_resp_t            w_resp_out;

   assign w_idx         = data_addr_i[ADDR_WIDTH+1:2];
   assign w_unused_addr = ^{data_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2], data_addr_i[1:0]};

   assign w_gnt      = data_req_i && (r_count < c_max_out) && !rst_i;
   assign data_gnt_o = w_gnt;

   // RAM contents survive reset.
   always_ff @(posedge clk_i) begin
      if (w_gnt && data_we_i) begin
         for (int b = 0; b < int'(DATA_BE_WIDTH); b++) begin
            if (data_be_i[b]) begin
               r_mem[w_idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      w_resp_in       = '0;
      w_resp_in.valid = w_gnt;
      if (w_gnt && !data_we_i) begin
         w_resp_in.rdata = r_mem[w_idx];
      end
   end

   data_mem_responder_resp_delay_line #(
      .DEPTH (READ_LATENCY)
   ) u_delay (
      .clk         (clk_i),
      .rst         (rst_i),
      .i_resp      (w_resp_in),
      .o_resp      (w_resp_out),
      .o_last_load (w_retire)
   );

   // A request stops counting on the edge that places it on rvalid, so the
   // slot is reusable in the same cycle the response is presented.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count <= '0;
      end else if (w_gnt && !w_retire) begin
         r_count <= r_count + c_one;
      end else if (!w_gnt && w_retire) begin
         r_count <= r_count - c_one;
      end
   end

   assign data_rvalid_o = w_resp_out.valid;
   assign data_rdata_o  = w_resp_out.rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench; four latency variants share one stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int N = 4;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 2 : 3;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, req_i, we_i;
   logic [31:0] addr_i, wdata_i;
   logic [3:0]  be_i;
   logic [N-1:0]       gnt, rvalid;
   logic [N-1:0][31:0] rdata;

   for (genvar k = 0; k < N; k++) begin : g_dut
      data_mem_responder #(
         .DATA_WIDTH      (32),
         .ADDR_WIDTH      (10),
         .READ_LATENCY    (lat_of(k)),
         .MAX_OUTSTANDING (2)
      ) u_dut (
         .clk_i         (clk),
         .rst_i         (rst_i),
         .data_req_i    (req_i),
         .data_gnt_o    (gnt[k]),
         .data_addr_i   (addr_i),
         .data_we_i     (we_i),
         .data_be_i     (be_i),
         .data_wdata_i  (wdata_i),
         .data_rvalid_o (rvalid[k]),
         .data_rdata_o  (rdata[k])
      );
   end

   // Reference model: memory image plus a list of expected responses with due cycle.
   typedef struct { int due; logic [31:0] data; bit chk; } exp_t;
   exp_t        ring   [N][16];
   int          hd     [N] = '{default: 0};
   int          tl     [N] = '{default: 0};
   int          nrv    [N] = '{default: 0};
   logic [31:0] last_rd[N];
   logic [31:0] mmem   [N][1024];
   logic [3:0]  mknown [N][1024];
   int          cyc_now = 0;
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, k, act, exp, $time);
   endtask

   function automatic int inflight(input int k);
      int c = 0;
      for (int i = hd[k]; i < tl[k]; i++) if (ring[k][i % 16].due > cyc_now) c++;
      return c;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         bit   eg, vis;
         int   idx;
         exp_t e;
         eg  = req_i && (inflight(k) < 2) && !rst_i;
         vis = (hd[k] != tl[k]) && (ring[k][hd[k] % 16].due == cyc_now);
         chk("gnt", k, gnt[k], eg);
         chk("rvalid", k, rvalid[k], vis);
         if (vis) begin
            nrv[k]++;
            last_rd[k] = rdata[k];
            if (ring[k][hd[k] % 16].chk) chk("rdata", k, rdata[k], ring[k][hd[k] % 16].data);
         end else begin
            chk("rdata_idle", k, rdata[k], 32'h0);
         end
         // Advance the model across the coming rising edge.
         if (rst_i) begin
            hd[k] = tl[k];
         end else begin
            if (vis) hd[k]++;
            if (eg) begin
               idx   = int'(addr_i[11:2]);
               e.due = cyc_now + lat_of(k);
               if (we_i) begin
                  for (int b = 0; b < 4; b++) begin
                     if (be_i[b]) begin
                        mmem[k][idx][b*8 +: 8] = wdata_i[b*8 +: 8];
                        mknown[k][idx][b]      = 1'b1;
                     end
                  end
                  e.data = 32'h0;
                  e.chk  = 1'b1;
               end else begin
                  e.data = mmem[k][idx];
                  e.chk  = (mknown[k][idx] == 4'hF);
               end
               ring[k][tl[k] % 16] = e;
               tl[k]++;
            end
         end
      end
      cyc_now++;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic put(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = d;
      @(posedge clk);
      #1;
      req_i = 1'b0; we_i = $urandom_range(0, 1); addr_i = $urandom(); be_i = 4'hF; wdata_i = $urandom();
   endtask

   task automatic wait_resp(input int k, output logic [31:0] d);
      int t = 0;
      while (!rvalid[k] && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("resp_seen", k, {31'h0, rvalid[k]}, 32'h1);
      d = rdata[k];
   endtask

   task automatic read_chk(input int k, input logic [31:0] a, input logic [31:0] exp, input string nm);
      logic [31:0] d;
      req_i = 1'b1; we_i = 1'b0; addr_i = a;
      #1;
      chk({nm, "_gnt"}, k, {31'h0, gnt[k]}, 32'h1);
      @(posedge clk);
      #1;
      req_i = 1'b0; addr_i = $urandom();
      wait_resp(k, d);
      chk(nm, k, d, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int          n, snap;
      logic [7:0]  pat;
      for (int k = 0; k < N; k++) for (int i = 0; i < 1024; i++) mknown[k][i] = 4'h0;
      rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'h0; be_i = 4'hF;
      idle(3);
      for (int k = 0; k < N; k++) chk("gnt_in_reset", k, {31'h0, gnt[k]}, 32'h0);
      rst_i = 1'b0; req_i = 1'b0;
      idle(1);
      for (int k = 0; k < N; k++) begin
         chk("reset_rvalid", k, {31'h0, rvalid[k]}, 32'h0);
         chk("reset_rdata", k, rdata[k], 32'h0);
      end

      // Single read of word 3 after loading it.
      put(1'b1, 32'h0000_000C, 4'hF, 32'hDEAD_BEEF);
      chk("wr_resp_valid", 0, {31'h0, rvalid[0]}, 32'h1);
      chk("wr_resp_rdata", 0, rdata[0], 32'h0);
      idle(6);
      read_chk(0, 32'h0000_000C, 32'hDEAD_BEEF, "single_read");
      idle(1);
      chk("rdata_after_resp", 0, rdata[0], 32'h0);

      // Byte enables, including an all-zero enable.
      put(1'b1, 32'h20, 4'hF, 32'h1122_3344);
      chk("be_wr1_rdata", 0, {rvalid[0], rdata[0][30:0]}, 32'h8000_0000);
      put(1'b1, 32'h20, 4'h5, 32'hAABB_CCDD);
      chk("be_wr2_rdata", 0, {rvalid[0], rdata[0][30:0]}, 32'h8000_0000);
      put(1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF);
      chk("be_wr0_rdata", 0, {rvalid[0], rdata[0][30:0]}, 32'h8000_0000);
      idle(6);
      read_chk(0, 32'h20, 32'h11BB_33DD, "be_read");
      idle(6);
      read_chk(2, 32'h22, 32'h11BB_33DD, "be_read_lat2");

      // Preload, then throughput on the latency-4 instance.
      for (int i = 0; i < 8; i++) begin
         put(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));
         idle(4);
      end
      idle(6);
      pat  = 8'b0011_0011;
      n    = 0;
      snap = nrv[1];
      for (int c = 0; c < 40 && n < 8; c++) begin
         req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100 + 32'(4 * n);
         #1;
         if (c < 8) chk("thru_gnt", 1, {31'h0, gnt[1]}, {31'h0, pat[c]});
         if (gnt[1]) n++;
         @(posedge clk);
         #1;
      end
      req_i = 1'b0;
      chk("thru_grants", 1, n, 8);
      idle(10);
      chk("thru_rvalids", 1, nrv[1] - snap, 8);

      // Full rate with alternating write/read on the latency-2 instance.
      for (int i = 0; i < 16; i++) begin
         req_i = 1'b1; we_i = (i % 2 == 0); addr_i = 32'h40; be_i = 4'hF; wdata_i = 32'h1000 + 32'(i);
         #1;
         chk("fullrate_gnt", 2, {31'h0, gnt[2]}, 32'h1);
         @(posedge clk);
         #1;
      end
      req_i = 1'b0;
      idle(6);
      chk("fullrate_last", 2, last_rd[2], 32'h0000_100E);

      // Address aliasing.
      put(1'b1, 32'h0000_1000, 4'hF, 32'h55);
      idle(6);
      read_chk(0, 32'h0000_0000, 32'h55, "wrap_read0");
      idle(4);
      read_chk(0, 32'h0000_0003, 32'h55, "wrap_read3");

      // Reset with two reads in flight on the latency-3 instance.
      idle(6);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
      #1;
      chk("mid_gnt0", 3, {31'h0, gnt[3]}, 32'h1);
      @(posedge clk);
      #1;
      addr_i = 32'h0C;
      #1;
      chk("mid_gnt1", 3, {31'h0, gnt[3]}, 32'h1);
      @(posedge clk);
      #1;
      rst_i = 1'b1; we_i = 1'b1;
      #1;
      chk("mid_rst_gnt", 3, {31'h0, gnt[3]}, 32'h0);
      snap = nrv[3];
      @(posedge clk);
      #1;
      rst_i = 1'b0; req_i = 1'b0;
      idle(8);
      chk("mid_no_rvalid", 3, nrv[3] - snap, 0);
      read_chk(3, 32'h20, 32'h11BB_33DD, "post_rst_read");

      idle(4);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
